// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle CPU: word RAM plus an MMIO page holding a compare timer and an 8N1 transmitter.
// Build option DMEM_TXFIFO_EN places a 4-entry FIFO in front of the transmitter; without it a single holding register is used.
module dmem_responder #(
   parameter logic [31:0] RAM_BASE     = 32'h1001_0000,
   parameter int          RAM_DEPTH    = 1024,
   parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
   parameter int          CLKS_PER_BIT = 868
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        cs,
   input  logic        dm_w,
   input  logic        dm_r,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        timer_irq
);

   localparam int AW = $clog2(RAM_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   logic [31:0]   mem_r [RAM_DEPTH];
   logic [31:0]   ram_off_s;
   logic [AW-1:0] ram_idx_s;
   logic          ram_hit_s;
   logic          mmio_hit_s;
   logic [1:0]    reg_sel_s;
   logic          wr_ok_s;
   logic          ram_we_s;
   logic          count_we_s;
   logic          cmp_we_s;
   logic          status_we_s;
   logic          txdata_we_s;
   logic          rd_ok_s;
   logic          unused_s;

   logic [31:0]   count_r;
   logic [31:0]   cmp_r;
   logic          flag_r;
   logic          match_s;
   logic [31:0]   status_s;
   logic          status_b0_s;
   logic          status_b2_s;

   tx_state_t     state_r, state_n;
   logic [CW-1:0] clk_cnt_r, clk_cnt_n;
   logic [2:0]    bit_idx_r, bit_idx_n;
   logic [7:0]    shift_r, shift_n;
   logic          tx_r, tx_n;
   logic          bit_done_s;
   logic          tx_idle_s;
   logic          start_s;
   logic [7:0]    start_data_s;

   // Address decode; RAM wins if the two windows were ever configured to overlap.
   assign ram_off_s  = addr - RAM_BASE;
   assign ram_hit_s  = (ram_off_s[31:2] < 30'(RAM_DEPTH));
   assign ram_idx_s  = ram_off_s[AW+1:2];
   assign mmio_hit_s = !ram_hit_s && (addr[31:4] == MMIO_BASE[31:4]);
   assign reg_sel_s  = addr[3:2];
   assign unused_s   = ^ram_off_s[1:0];

   // Writes are blocked entirely while reset is held low, RAM included.
   assign wr_ok_s     = cs && dm_w && reset;
   assign ram_we_s    = wr_ok_s && ram_hit_s;
   assign count_we_s  = wr_ok_s && mmio_hit_s && (reg_sel_s == 2'd0);
   assign cmp_we_s    = wr_ok_s && mmio_hit_s && (reg_sel_s == 2'd1);
   assign status_we_s = wr_ok_s && mmio_hit_s && (reg_sel_s == 2'd2);
   assign txdata_we_s = wr_ok_s && mmio_hit_s && (reg_sel_s == 2'd3);
   assign rd_ok_s     = cs && dm_r;

   // RAM storage; contents deliberately survive reset.
   always_ff @(posedge clk_in) begin
      if (ram_we_s) begin
         mem_r[ram_idx_s] <= wdata;
      end
   end

   assign match_s = (count_r == cmp_r);

   // Free-running counter, compare register and sticky match flag (set beats clear).
   always_ff @(posedge clk_in) begin
      if (!reset) begin
         count_r <= 32'd0;
         cmp_r   <= 32'hFFFF_FFFF;
         flag_r  <= 1'b0;
      end else begin
         if (count_we_s) begin
            count_r <= wdata;
         end else begin
            count_r <= count_r + 32'd1;
         end
         if (cmp_we_s) begin
            cmp_r <= wdata;
         end
         if (match_s) begin
            flag_r <= 1'b1;
         end else if (status_we_s && wdata[1]) begin
            flag_r <= 1'b0;
         end
      end
   end

   assign tx_idle_s = (state_r == TX_IDLE);

`ifdef DMEM_TXFIFO_EN
   logic [7:0] fifo_r [4];
   logic [1:0] wr_ptr_r;
   logic [1:0] rd_ptr_r;
   logic [2:0] fill_r;
   logic       fifo_full_s;
   logic       fifo_empty_s;
   logic       push_s;
   logic       pop_s;

   assign fifo_full_s  = (fill_r == 3'd4);
   assign fifo_empty_s = (fill_r == 3'd0);
   assign push_s       = txdata_we_s && !fifo_full_s;
   assign pop_s        = tx_idle_s && !fifo_empty_s;
   assign start_s      = pop_s;
   assign start_data_s = fifo_r[rd_ptr_r];
   assign status_b0_s  = fifo_full_s;
   assign status_b2_s  = fifo_empty_s && tx_idle_s;

   // FIFO storage.
   always_ff @(posedge clk_in) begin
      if (push_s) begin
         fifo_r[wr_ptr_r] <= wdata[7:0];
      end
   end

   // FIFO pointers and fill level.
   always_ff @(posedge clk_in) begin
      if (!reset) begin
         wr_ptr_r <= 2'd0;
         rd_ptr_r <= 2'd0;
         fill_r   <= 3'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + 2'd1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 2'd1;
         end
         case ({push_s, pop_s})
            2'b10:   fill_r <= fill_r + 3'd1;
            2'b01:   fill_r <= fill_r - 3'd1;
            default: fill_r <= fill_r;
         endcase
      end
   end
`else
   assign start_s      = txdata_we_s && tx_idle_s;
   assign start_data_s = wdata[7:0];
   assign status_b0_s  = !tx_idle_s;
   assign status_b2_s  = 1'b0;
`endif

   assign status_s = {29'd0, status_b2_s, flag_r, status_b0_s};

   // Combinational read mux; the CPU consumes this in the same cycle.
   always_comb begin
      rdata = 32'd0;
      if (rd_ok_s && ram_hit_s) begin
         rdata = mem_r[ram_idx_s];
      end else if (rd_ok_s && mmio_hit_s) begin
         case (reg_sel_s)
            2'd0:    rdata = count_r;
            2'd1:    rdata = cmp_r;
            2'd2:    rdata = status_s;
            default: rdata = 32'd0;
         endcase
      end else begin
         rdata = 32'd0;
      end
   end

   assign bit_done_s = (clk_cnt_r == CW'(CLKS_PER_BIT - 1));

   // Transmitter state register; tx is registered so the line never glitches.
   always_ff @(posedge clk_in) begin
      if (!reset) begin
         state_r   <= TX_IDLE;
         clk_cnt_r <= {CW{1'b0}};
         bit_idx_r <= 3'd0;
         shift_r   <= 8'd0;
         tx_r      <= 1'b1;
      end else begin
         state_r   <= state_n;
         clk_cnt_r <= clk_cnt_n;
         bit_idx_r <= bit_idx_n;
         shift_r   <= shift_n;
         tx_r      <= tx_n;
      end
   end

   // Transmitter next-state logic; tx_n is the line level for the coming cycle.
   always_comb begin
      state_n   = state_r;
      clk_cnt_n = clk_cnt_r;
      bit_idx_n = bit_idx_r;
      shift_n   = shift_r;
      tx_n      = tx_r;
      case (state_r)
         TX_IDLE: begin
            tx_n = 1'b1;
            if (start_s) begin
               state_n   = TX_START;
               clk_cnt_n = {CW{1'b0}};
               bit_idx_n = 3'd0;
               shift_n   = start_data_s;
               tx_n      = 1'b0;
            end else begin
               state_n = TX_IDLE;
            end
         end
         TX_START: begin
            if (bit_done_s) begin
               state_n   = TX_DATA;
               clk_cnt_n = {CW{1'b0}};
               tx_n      = shift_r[0];
            end else begin
               clk_cnt_n = clk_cnt_r + CW'(1);
            end
         end
         TX_DATA: begin
            if (bit_done_s) begin
               clk_cnt_n = {CW{1'b0}};
               if (bit_idx_r == 3'd7) begin
                  state_n   = TX_STOP;
                  bit_idx_n = 3'd0;
                  tx_n      = 1'b1;
               end else begin
                  bit_idx_n = bit_idx_r + 3'd1;
                  shift_n   = {1'b0, shift_r[7:1]};
                  tx_n      = shift_r[1];
               end
            end else begin
               clk_cnt_n = clk_cnt_r + CW'(1);
            end
         end
         TX_STOP: begin
            if (bit_done_s) begin
               state_n   = TX_IDLE;
               clk_cnt_n = {CW{1'b0}};
               tx_n      = 1'b1;
            end else begin
               clk_cnt_n = clk_cnt_r + CW'(1);
            end
         end
         default: begin
            state_n   = TX_IDLE;
            clk_cnt_n = {CW{1'b0}};
            bit_idx_n = 3'd0;
            tx_n      = 1'b1;
         end
      endcase
   end

   assign tx        = tx_r;
   assign timer_irq = flag_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: RAM, timer, serial transmitter and reset behaviour against a cycle-level model.
module tb_dmem_responder;

   localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
   localparam int          RAM_DEPTH = 1024;
   localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
   localparam int          CPB       = 4;
   localparam logic [31:0] A_COUNT   = MMIO_BASE + 32'h0;
   localparam logic [31:0] A_CMP     = MMIO_BASE + 32'h4;
   localparam logic [31:0] A_STATUS  = MMIO_BASE + 32'h8;
   localparam logic [31:0] A_TXDATA  = MMIO_BASE + 32'hC;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        cs;
   logic        dm_w;
   logic        dm_r;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        tx;
   logic        timer_irq;

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   logic [31:0] cnt_base = 32'd0;
   int unsigned cnt_cyc = 0;
   logic [31:0] ram_model [int];

   dmem_responder #(
      .RAM_BASE(RAM_BASE), .RAM_DEPTH(RAM_DEPTH), .MMIO_BASE(MMIO_BASE), .CLKS_PER_BIT(CPB)
   ) dut (
      .clk_in(clk_in), .reset(reset), .cs(cs), .dm_w(dm_w), .dm_r(dm_r),
      .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx), .timer_irq(timer_irq)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   // COUNT = last written value plus the number of edges since that write.
   function automatic logic [31:0] exp_count();
      return cnt_base + 32'(cyc - cnt_cyc);
   endfunction

   // Frame bit j: 0 start, 1..8 data LSB first, 9 stop.
   function automatic logic frame_bit(input logic [7:0] d, input int j);
      if (j == 0) return 1'b0;
      if (j >= 1 && j <= 8) return d[j-1];
      return 1'b1;
   endfunction

   function automatic logic in_frame(input int k, input int s);
      return (s >= 0) && (k >= s) && (k < s + 10*CPB);
   endfunction

   function automatic logic exp_tx(input int k, input int s1, input logic [7:0] d1,
                                   input int s2, input logic [7:0] d2);
      if (in_frame(k, s1)) return frame_bit(d1, (k - s1) / CPB);
      if (in_frame(k, s2)) return frame_bit(d2, (k - s2) / CPB);
      return 1'b1;
   endfunction

   task automatic next_cycle();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      cs = 1'b1; dm_w = 1'b1; dm_r = 1'b0; addr = a; wdata = d;
      next_cycle();
      cs = 1'b0; dm_w = 1'b0;
      if (a[31:2] == A_COUNT[31:2]) begin
         cnt_base = d;
         cnt_cyc  = cyc;
      end
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d);
      cs = 1'b1; dm_r = 1'b1; dm_w = 1'b0; addr = a;
      #1;
      d = rdata;
      cs = 1'b0; dm_r = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      reset = 1'b0; cs = 1'b0; dm_w = 1'b0; dm_r = 1'b0; addr = 32'd0; wdata = 32'd0;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
         checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
         checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
      end
      cnt_base = 32'd0; cnt_cyc = cyc;
      reset = 1'b1;
      do_read(A_COUNT, r);
      checks++; if (r !== exp_count()) begin errors++; $display("FAIL reset_count got=%h exp=%h", r, exp_count()); end
      do_read(A_CMP, r);
      checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp got=%h exp=ffffffff", r); end
      do_read(A_STATUS, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_status got=%h exp=0", r); end
      do_read(A_TXDATA, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL txdata_read got=%h exp=0", r); end
   endtask

   task automatic test_ram();
      logic [31:0] r;
      int idx;
      do_write(RAM_BASE + 32'h4, 32'hDEAD_BEEF); ram_model[1] = 32'hDEAD_BEEF;
      do_write(RAM_BASE, 32'h1234_5678);         ram_model[0] = 32'h1234_5678;
      do_read(RAM_BASE + 32'h4, r);
      checks++; if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_word1 got=%h exp=deadbeef", r); end
      do_read(RAM_BASE, r);
      checks++; if (r !== 32'h1234_5678) begin errors++; $display("FAIL ram_word0 got=%h exp=12345678", r); end
      do_read(32'h0000_0000, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", r); end
      // Writes just outside the window must be dropped, not aliased.
      do_write(RAM_BASE + 32'(RAM_DEPTH*4), 32'hBAD0_0001);
      do_write(RAM_BASE - 32'h4, 32'hBAD0_0002);
      do_read(RAM_BASE + 32'(RAM_DEPTH*4), r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL above_ram got=%h exp=0", r); end
      do_read(RAM_BASE - 32'h4, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL below_ram got=%h exp=0", r); end
      do_write(RAM_BASE + 32'((RAM_DEPTH-1)*4) + 32'h3, 32'h0F0F_A5A5); ram_model[RAM_DEPTH-1] = 32'h0F0F_A5A5;
      for (int i = 0; i < 24; i++) begin
         idx = int'($urandom_range(0, RAM_DEPTH-1));
         r = $urandom;
         do_write(RAM_BASE + 32'(idx*4), r);
         ram_model[idx] = r;
      end
      foreach (ram_model[k]) begin
         do_read(RAM_BASE + 32'(k*4), r);
         checks++; if (r !== ram_model[k]) begin errors++; $display("FAIL ram_rand idx=%0d got=%h exp=%h", k, r, ram_model[k]); end
      end
      cs = 1'b0; dm_r = 1'b1; addr = RAM_BASE; #1;
      checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL read_no_cs got=%h exp=0", rdata); end
      dm_r = 1'b0;
      // Read and write in the same cycle: old value visible, new value committed.
      do_write(RAM_BASE + 32'd20, 32'h1111_2222);
      cs = 1'b1; dm_r = 1'b1; dm_w = 1'b1; addr = RAM_BASE + 32'd20; wdata = 32'h3333_4444; #1;
      checks++; if (rdata !== 32'h1111_2222) begin errors++; $display("FAIL rw_prewrite got=%h exp=11112222", rdata); end
      next_cycle();
      cs = 1'b0; dm_r = 1'b0; dm_w = 1'b0;
      ram_model[5] = 32'h3333_4444;
      do_read(RAM_BASE + 32'd20, r);
      checks++; if (r !== 32'h3333_4444) begin errors++; $display("FAIL rw_commit got=%h exp=33334444", r); end
   endtask

   task automatic test_timer();
      logic [31:0] r;
      logic [31:0] v;
      do_write(A_COUNT, 32'd1000);
      do_write(A_CMP, 32'd10);
      do_write(A_STATUS, 32'h2);
      do_write(A_COUNT, 32'd0);
      for (int k = 1; k <= 11; k++) begin
         next_cycle();
         checks++;
         if (timer_irq !== (k >= 11)) begin errors++; $display("FAIL irq_edge k=%0d got=%b exp=%b", k, timer_irq, (k >= 11)); end
      end
      do_read(A_STATUS, r);
      checks++; if (r !== 32'h2) begin errors++; $display("FAIL status_match got=%h exp=2", r); end
      do_write(A_STATUS, 32'h2);
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", timer_irq); end
      do_write(A_STATUS, 32'h1);
      do_read(A_STATUS, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL status_bit0_wr got=%h exp=0", r); end
      for (int i = 0; i < 6; i++) begin
         v = $urandom;
         do_write(A_COUNT, v);
         repeat ($urandom_range(0, 5)) next_cycle();
         do_read(A_COUNT, r);
         checks++; if (r !== exp_count()) begin errors++; $display("FAIL count_rand got=%h exp=%h", r, exp_count()); end
      end
      do_write(A_COUNT, 32'hFFFF_FFFE);
      next_cycle();
      do_read(A_COUNT, r);
      checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_max got=%h exp=ffffffff", r); end
      next_cycle();
      do_read(A_COUNT, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL count_wrap got=%h exp=0", r); end
      do_write(A_COUNT, 32'd5);
      do_read(A_COUNT, r);
      checks++; if (r !== 32'd5) begin errors++; $display("FAIL count_load got=%h exp=5", r); end
      next_cycle();
      do_read(A_COUNT, r);
      checks++; if (r !== 32'd6) begin errors++; $display("FAIL count_load_inc got=%h exp=6", r); end
      // Match fires on the same edge as the clear write: set must win.
      do_write(A_CMP, 32'd100);
      do_write(A_COUNT, 32'd98);
      do_write(A_STATUS, 32'h2);
      next_cycle();
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_pre_collide got=%b exp=0", timer_irq); end
      do_write(A_STATUS, 32'h2);
      checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got=%b exp=1", timer_irq); end
      do_write(A_STATUS, 32'h2);
      checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_clear2 got=%b exp=0", timer_irq); end
   endtask

   // Sends d1; optional write of dbusy at sample busy_k, optional write of d2 at sample chain_k.
   task automatic run_frames(input logic [7:0] d1, input int busy_k, input logic [7:0] dbusy,
                             input int chain_k, input logic [7:0] d2, input int n);
      logic [31:0] st;
      int s2;
      logic eb;
      s2 = (chain_k >= 0) ? chain_k + 1 : -1;
      do_write(A_TXDATA, {24'd0, d1});
      for (int k = 0; k < n; k++) begin
         checks++;
         if (tx !== exp_tx(k, 0, d1, s2, d2)) begin
            errors++; $display("FAIL tx_line k=%0d got=%b exp=%b", k, tx, exp_tx(k, 0, d1, s2, d2));
         end
         if (k == busy_k) begin
            do_write(A_TXDATA, {24'd0, dbusy});
         end else if (k == chain_k) begin
            do_write(A_TXDATA, {24'd0, d2});
         end else begin
            do_read(A_STATUS, st);
            eb = in_frame(k, 0) || in_frame(k, s2);
            checks++;
            if (st[0] !== eb) begin errors++; $display("FAIL tx_busy k=%0d got=%b exp=%b", k, st[0], eb); end
            next_cycle();
         end
      end
   endtask

   task automatic test_tx();
      logic [7:0] d;
      run_frames(8'hA5, 10, 8'h3C, -1, 8'h00, 50);
      d = 8'($urandom);
      run_frames(d, -1, 8'h00, 40, 8'($urandom), 90);
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      logic [31:0] v;
      v = $urandom;
      do_write(RAM_BASE + 32'h40, v);
      do_write(A_TXDATA, 32'h0000_00C3);
      repeat (15) next_cycle();
      reset = 1'b0; cs = 1'b1; dm_w = 1'b1; addr = RAM_BASE + 32'h40; wdata = ~v;
      next_cycle();
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_mid_tx got=%b exp=1", tx); end
      addr = A_COUNT; wdata = 32'd1234;
      next_cycle();
      cs = 1'b0; dm_w = 1'b0;
      cnt_base = 32'd0; cnt_cyc = cyc;
      reset = 1'b1;
      do_read(A_COUNT, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_mid_count got=%h exp=0", r); end
      do_read(A_STATUS, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_mid_status got=%h exp=0", r); end
      do_read(RAM_BASE + 32'h40, r);
      checks++; if (r !== v) begin errors++; $display("FAIL reset_mid_ram got=%h exp=%h", r, v); end
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_mid_idle i=%0d got=%b exp=1", i, tx); end
      end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_timer();
      test_tx();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the single-cycle CPU's data port; the CPU is the initiator, and this block answers its CS/DM_W/DM_R accesses.
- Decodes the CPU's ALU address into two regions:
  - a word RAM in the data segment;
  - an MMIO peripheral page containing a free-running compare timer and an 8N1 serial transmitter.
- Read data is combinational, because the CPU consumes it in the same cycle. Writes commit on the clock edge.

Parameters:
- RAM_BASE, 32'h1001_0000, byte base address of the RAM region.
- RAM_DEPTH, 1024, number of 32-bit RAM words; must be a power of 2.
- MMIO_BASE, 32'hFFFF_0000, byte base address of the 16-byte MMIO page.
- CLKS_PER_BIT, 868, clocks per serial bit; must be at least 2.

Ports:
- clk_in  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk_in.
- cs  in  1  chip select from CPU.
- dm_w  in  1  write strobe.
- dm_r  in  1  read strobe.
- addr  in  32  byte address (CPU ALU result); addr[1:0] ignored.
- wdata  in  32  store data (CPU rt).
- rdata  out  32  load data to CPU; combinational.
- tx  out  1  serial output; idles high.
- timer_irq  out  1  level, equals the match flag.

Behaviour:
- Decode:
  - RAM hit when (addr - RAM_BASE) >> 2 < RAM_DEPTH; word index = (addr - RAM_BASE) >> 2.
  - MMIO hit when addr[31:4] == MMIO_BASE[31:4]; register = addr[3:2].
- Read path:
  - rdata = selected word when cs && dm_r && hit; otherwise 32'h0.
  - Unmapped reads return 0. Reads have no side effects.
- Write path:
  - A write commits at the edge when cs && dm_w && hit. Unmapped writes are dropped.
  - When dm_r and dm_w are both asserted, the write commits and rdata shows the pre-write value.
- MMIO registers:
  - 0x0 COUNT (R/W): increments by 1 every clock and wraps 0xFFFFFFFF -> 0. A software write loads wdata that cycle; the write takes priority over the increment.
  - 0x4 CMP (R/W): compare value.
  - 0x8 STATUS:
    - bit0 tx_busy; bit1 match flag; other bits read 0.
    - Writing 1 to bit1 clears the flag; writing bit0 has no effect.
  - 0xC TXDATA (W): if the transmitter is idle, wdata[7:0] is latched and transmission starts next cycle; if busy, the write is ignored. Reads return 0.
- Match flag: set on the edge where COUNT == CMP (pre-increment value). A set and a clear in the same cycle resolve to set.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - START holds tx=0 for CLKS_PER_BIT clocks.
  - DATA sends 8 bits, LSB first, each for CLKS_PER_BIT clocks.
  - STOP holds tx=1 for CLKS_PER_BIT clocks.
  - tx_busy = (state != IDLE). A new TXDATA write is accepted in the first cycle back in IDLE.
- Reset values: COUNT=0, CMP=32'hFFFF_FFFF, flag=0, timer_irq=0, FSM=IDLE, tx=1, bit counters=0. rdata follows its inputs and is 0 while cs=0.
- Reset during operation: any frame in flight is aborted and tx returns high on the next edge. RAM contents are not affected by reset.
- Reset vs. access: while reset=0, all writes are ignored, including RAM writes.

Optional Feature:
- Macro: DMEM_TXFIFO_EN.
- Defined:
  - A 4-entry TX FIFO sits in front of the FSM. A TXDATA write pushes unless the FIFO is full; a push while full is dropped.
  - The FSM pops whenever it is IDLE and the FIFO is non-empty, so back-to-back frames are sent with no idle bit between them.
  - STATUS bit0 = FIFO full; STATUS bit2 = FIFO empty and FSM IDLE.
  - Reset empties the FIFO.
- Undefined: single holding register, with behaviour exactly as described above.

Test Plan:
- RAM: SW 0xDEADBEEF to 0x10010004, then LW from 0x10010004 -> rdata = 0xDEADBEEF. LW from 0x10010000 returns its own word. LW from 0x00000000 -> rdata = 0.
- Timer: write CMP = 10 and COUNT = 0 -> timer_irq rises on the 11th edge. Write STATUS = 0x2 -> timer_irq = 0 the next cycle. COUNT keeps running and wraps after 0xFFFFFFFF.
- Serial (CLKS_PER_BIT = 4): write TXDATA = 0xA5 -> tx sequence 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each bit held 4 clocks. STATUS bit0 = 1 for exactly 40 clocks.
- Busy write: while a frame is in flight, write TXDATA = 0x3C -> the write is ignored and the frame finishes as 0xA5. With DMEM_TXFIFO_EN defined, 0x3C is sent immediately after 0xA5.
- Reset during operation: pull reset low mid-DATA -> tx = 1, STATUS = 0 and COUNT = 0 on the next edge. A previously stored RAM word still reads back unchanged.
- Simultaneous events: write COUNT = 5 while the increment fires -> COUNT reads 6 one cycle later. Flag set and a write of 1 to STATUS bit1 in the same cycle -> flag stays 1.
